// File: rtl/loader_pkg.sv
// loader_pkg
//   Shared definitions for the host backdoor memory loader.
//   - ld_state_e : loader FSM state encoding (IDLE / LOAD / DONE)
//   - LD_DATA_W  : default word width, matches the SRAM backdoor data bus
//   - LD_ADDR_W  : default backdoor word-address width
package loader_pkg;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } ld_state_e;

    localparam int LD_DATA_W = 32;
    localparam int LD_ADDR_W = 10;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with a combinational head read. Pointers carry one
//   extra bit so that full and empty can be told apart when the index
//   bits are equal.
//
//   Parameters: DATA_W (entry width), DEPTH (entries, power of two, >= 2)
//   Ports:
//     clk      in   clock, rising edge
//     rst_n    in   synchronous active-low reset (flushes pointers)
//     push_i   in   write wdata_i at the tail (ignored while full)
//     wdata_i  in   DATA_W tail data
//     pop_i    in   drop the head entry (ignored while empty)
//     rdata_o  out  DATA_W head entry, valid while !empty_o
//     full_o   out  no free entry
//     empty_o  out  no valid entry
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW:0]       wptr_q, rptr_q;
    logic              do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Full: index bits match but the lap bit differs.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PW] != rptr_q[PW]) &&
                     (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign rdata_o = mem_q[rptr_q[PW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage needs no reset; contents are only visible behind valid pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[PW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/host_mem_loader.sv
// host_mem_loader
//   Accepts a load command (base word address, word count) and a stream
//   of data words, buffers the words in a small FIFO and replays them as
//   single-cycle backdoor SRAM writes. Writes are only issued while the
//   accelerator reports idle, so the scratchpad is never touched during
//   computation; the input side keeps filling the FIFO meanwhile.
//
//   Parameters: DATA_W (word width), ADDR_W (word address width),
//               FIFO_DEPTH (buffer entries, power of two, >= 2)
//   Ports:
//     clk, rst_n       clock / synchronous active-low reset
//     cmd_valid/ready  command handshake, ready only in IDLE
//     cmd_base         first target word address
//     cmd_len          word count, 0 .. 2^ADDR_W
//     s_valid/ready    data beat handshake
//     s_data           data beat
//     acc_idle         accelerator idle, gates SRAM writes
//     host_mem_we      registered write strobe, one cycle per word
//     host_mem_addr    registered write address
//     host_mem_wdata   registered write data
//     busy             high while a command is in progress (LOAD, DONE)
//     done             one-cycle completion pulse
module host_mem_loader
    import loader_pkg::*;
#(
    parameter int DATA_W     = LD_DATA_W,
    parameter int ADDR_W     = LD_ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              acc_idle,
    output logic              host_mem_we,
    output logic [ADDR_W-1:0] host_mem_addr,
    output logic [DATA_W-1:0] host_mem_wdata,
    output logic              busy,
    output logic              done
);

    ld_state_e         state_q;
    logic              cmd_ready_q, busy_q, done_q;

    // Counters: next write address, beats still to accept, words still to write.
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   acc_left_q, acc_left_d;
    logic [ADDR_W:0]   wr_left_q, wr_left_d;

    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              in_load, cmd_hs, push, pop;

    assign in_load = (state_q == LD_LOAD);
    assign cmd_hs  = cmd_valid && cmd_ready_q;

    // Never push while full, even if a pop frees a slot this same cycle:
    // keeps s_ready independent of acc_idle.
    assign s_ready = in_load && !fifo_full && (acc_left_q != '0);
    assign push    = s_valid && s_ready;
    assign pop     = in_load && !fifo_empty && acc_idle;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (s_data),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Control FSM; handshake/status outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= LD_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                LD_IDLE: begin
                    if (cmd_hs) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (cmd_len == '0) begin
                            state_q <= LD_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= LD_LOAD;
                        end
                    end
                end
                LD_LOAD: begin
                    // wr_left hits zero on the edge that launches the last
                    // write, so this fires after that write cycle has ended.
                    if (wr_left_q == '0) begin
                        state_q <= LD_DONE;
                        done_q  <= 1'b1;
                    end
                end
                LD_DONE: begin
                    state_q     <= LD_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q     <= LD_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        addr_d     = addr_q;
        acc_left_d = acc_left_q;
        wr_left_d  = wr_left_q;
        if (cmd_hs) begin
            addr_d     = cmd_base;
            acc_left_d = cmd_len;
            wr_left_d  = cmd_len;
        end else begin
            if (push) acc_left_d = acc_left_q - 1'b1;
            if (pop) begin
                addr_d    = addr_q + 1'b1;     // wraps modulo 2^ADDR_W
                wr_left_d = wr_left_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q     <= '0;
            acc_left_q <= '0;
            wr_left_q  <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            addr_q     <= addr_d;
            acc_left_q <= acc_left_d;
            wr_left_q  <= wr_left_d;
            we_q       <= pop;
            if (pop) begin
                waddr_q <= addr_q;
                wdata_q <= fifo_head;
            end
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign host_mem_we    = we_q;
    assign host_mem_addr  = waddr_q;
    assign host_mem_wdata = wdata_q;

endmodule

// File: tb/tb_host_mem_loader.sv
// tb_host_mem_loader
//   Randomized bench for host_mem_loader. The reference model tracks, per
//   command, the accepted beats in a queue plus simple counts (accepted,
//   written) and from those predicts s_ready, each write, its address and
//   data, and the done pulse.
module tb_host_mem_loader;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_base;
    logic [10:0] cmd_len;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        acc_idle;
    logic        host_mem_we;
    logic [9:0]  host_mem_addr;
    logic [31:0] host_mem_wdata;
    logic        busy;
    logic        done;

    int checks;
    int errors;

    logic [31:0] sram [1024];

    always #5 clk = ~clk;

    host_mem_loader #(
        .DATA_W     (32),
        .ADDR_W     (10),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_base       (cmd_base),
        .cmd_len        (cmd_len),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .acc_idle       (acc_idle),
        .host_mem_we    (host_mem_we),
        .host_mem_addr  (host_mem_addr),
        .host_mem_wdata (host_mem_wdata),
        .busy           (busy),
        .done           (done)
    );

    // Behavioural SRAM behind the backdoor port.
    always @(posedge clk) begin
        if (host_mem_we) sram[host_mem_addr] <= host_mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_s_ready",   32'(s_ready), 32'd0);
        chk("rst_we",        32'(host_mem_we), 32'd0);
        chk("rst_busy",      32'(busy), 32'd0);
        chk("rst_done",      32'(done), 32'd0);
        chk("rst_addr",      32'(host_mem_addr), 32'd0);
        chk("rst_wdata",     host_mem_wdata, 32'd0);
    endtask

    // One command from IDLE to the first IDLE cycle after done.
    // vprob/iprob: percent chance of s_valid / acc_idle per cycle,
    // idle_hold: acc_idle forced low for this many cycles after acceptance,
    // stray: drive s_valid while the command is presented in IDLE,
    // fixed: use the 0x02020202, 0x03030303, ... data pattern.
    task automatic run_load(input logic [9:0] base, input int len, input int vprob,
                            input int iprob, input int idle_hold, input bit stray,
                            input bit fixed);
        logic [31:0] q[$];
        logic [31:0] exp_d;
        logic [9:0]  ea;
        int   n_acc, n_pop, wr_idx, occ, done_cyc;
        bit   exp_we, exp_sr, fin;

        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        cmd_valid = 1'b1;
        cmd_base  = base;
        cmd_len   = 11'(len);
        s_valid   = stray;
        s_data    = $urandom;
        acc_idle  = 1'b1;
        chk("idle_s_ready", 32'(s_ready), 32'd0);

        n_acc = 0; n_pop = 0; wr_idx = 0; exp_we = 1'b0; fin = 1'b0;
        done_cyc = (len == 0) ? 1 : -1;

        for (int cyc = 1; cyc < 400; cyc++) begin
            tick();
            cmd_valid = 1'b0;

            // Observe the results of the previous edge.
            chk("we", 32'(host_mem_we), 32'(exp_we));
            if (host_mem_we && exp_we && q.size() > 0) begin
                ea    = base + 10'(wr_idx);
                exp_d = q.pop_front();
                chk("addr", 32'(host_mem_addr), 32'(ea));
                chk("data", host_mem_wdata, exp_d);
                wr_idx++;
            end
            chk("done", 32'(done), 32'(cyc == done_cyc));
            chk("busy", 32'(busy), 32'd1);
            if (cyc == done_cyc) begin
                chk("done_s_ready", 32'(s_ready), 32'd0);
                chk("done_words", 32'(wr_idx), 32'(len));
                fin = 1'b1;
                break;
            end

            // Model: readiness and write for the coming edge.
            occ    = n_acc - n_pop;
            exp_sr = (n_acc < len) && (occ < DEPTH);
            chk("s_ready", 32'(s_ready), 32'(exp_sr));

            acc_idle = (cyc > idle_hold) && (int'($urandom_range(99)) < iprob);
            s_valid  = (int'($urandom_range(99)) < vprob);
            s_data   = fixed ? 32'h01010101 * 32'(n_acc + 2) : $urandom;

            exp_we = (occ > 0) && acc_idle;
            if (exp_we) begin
                n_pop++;
                if (n_pop == len) done_cyc = cyc + 2;
            end
            if (s_valid && s_ready) begin
                q.push_back(s_data);
                n_acc++;
            end
        end
        if (!fin) chk("timeout", 32'd0, 32'd1);

        s_valid = stray;
        tick();
        chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_done", 32'(done), 32'd0);
        chk("post_we", 32'(host_mem_we), 32'd0);
        chk("post_s_ready", 32'(s_ready), 32'd0);
        s_valid = 1'b0;
    endtask

    initial begin
        int nw;
        checks = 0;
        errors = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0;
        s_valid = 1'b0; s_data = '0; acc_idle = 1'b1;
        tick();
        tick();
        chk_reset_vals();
        rst_n = 1'b1;

        // Basic load, back-to-back data, accelerator idle.
        run_load(10'h000, 4, 100, 100, 0, 1'b0, 1'b1);
        chk("sram0", sram[0], 32'h02020202);
        chk("sram3", sram[3], 32'h05050505);

        // Idle gating: FIFO fills, no writes until acc_idle returns.
        run_load(10'h000, 4, 100, 100, 10, 1'b0, 1'b1);

        // Address wrap, with stray beats in IDLE.
        run_load(10'h3FE, 3, 100, 100, 0, 1'b1, 1'b0);
        chk("sram_wrap", sram[0], host_mem_wdata);

        // Zero length.
        run_load(10'h123, 0, 100, 100, 0, 1'b1, 1'b0);

        // Reset after two of six words are written.
        cmd_valid = 1'b1; cmd_base = 10'h100; cmd_len = 11'd6;
        acc_idle = 1'b1; s_valid = 1'b1; s_data = $urandom;
        nw = 0;
        for (int i = 0; i < 50 && nw < 2; i++) begin
            tick();
            cmd_valid = 1'b0;
            s_data = $urandom;
            if (host_mem_we) nw++;
        end
        chk("mid_writes", 32'(nw), 32'd2);
        rst_n = 1'b0;
        tick();
        chk_reset_vals();
        rst_n = 1'b1;
        s_valid = 1'b0;
        run_load(10'h055, 1, 100, 100, 0, 1'b0, 1'b0);

        // Random backpressure, idle toggling and stray beats.
        for (int t = 0; t < 12; t++) begin
            run_load(10'($urandom), int'($urandom_range(12, 1)),
                     int'($urandom_range(100, 30)), int'($urandom_range(100, 40)),
                     int'($urandom_range(5, 0)), 1'b1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/host_mem_loader.md
# host_mem_loader

Upstream feeder for `accelerator_soc`'s host backdoor memory port (`host_mem_we/addr/wdata`). It accepts a load command (base address, word count) and a valid/ready stream of 32-bit words, then buffers them in a small FIFO. It replays them as single-cycle SRAM writes, gated by the accelerator's idle indication, so the host never writes scratchpad memory while the array is computing.

## Interface
- `DATA_W`, 32, word width; matches `host_mem_wdata`.
- `ADDR_W`, 10, backdoor address width; matches `host_mem_addr`.
- `FIFO_DEPTH`, 4, buffer entries; must be a power of two and ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  load command valid.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_base`  in  ADDR_W  first target word address.
- `cmd_len`  in  ADDR_W+1  number of words, 0..2^ADDR_W.
- `s_valid`  in  1  data beat valid.
- `s_ready`  out  1  data beat accepted when `s_valid && s_ready`.
- `s_data`  in  DATA_W  data beat.
- `acc_idle`  in  1  accelerator idle; writes are issued only while high.
- `host_mem_we`  out  1  registered write strobe.
- `host_mem_addr`  out  ADDR_W  registered write address.
- `host_mem_wdata`  out  DATA_W  registered write data.
- `busy`  out  1  high in LOAD and DONE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, LOAD, DONE.
- **IDLE:** `cmd_ready=1`. A handshake latches `cmd_base` into the address counter and `cmd_len` into both `acc_left` and `wr_left`.
  - If `cmd_len==0`, the next state is DONE.
  - Otherwise, the next state is LOAD.
- **LOAD:**
  - `s_ready = !fifo_full && acc_left!=0`. There is no push-while-full, even when a pop happens in the same cycle.
  - Each accepted beat pushes to the FIFO and decrements `acc_left`.
  - Each cycle with `!fifo_empty && acc_idle`:
    - pop the head into the output registers with `host_mem_we=1`;
    - `host_mem_addr` takes the current address counter;
    - the counter increments modulo 2^ADDR_W, so 0x3FF wraps to 0x000;
    - `wr_left` decrements.
  - When `wr_left` reaches 0 and the last write cycle has ended, the next state is DONE.
- **DONE:** `done=1` for exactly one cycle, then IDLE.
- **`acc_idle` low:** writes stall, FIFO contents are held, and input continues until the FIFO is full. No data is lost or duplicated.
- **Simultaneous push and pop:** allowed when the FIFO is not full; occupancy is unchanged.
- **Stray beats:** `s_valid` in IDLE/DONE, or after `acc_left==0`, is not accepted (`s_ready=0`).
- **Reset:** `rst_n=0` at any point, including mid-LOAD, returns to IDLE, flushes the FIFO and clears the counters. Partially written data stays in the SRAM.

## Timing
Reset values (after `rst_n` is low at a rising edge):
- `cmd_ready=1`
- `s_ready=0`, `host_mem_we=0`, `busy=0`, `done=0`
- `host_mem_addr=0`, `host_mem_wdata=0`

Latency and throughput:
- A beat accepted at edge N is written at edge N+1, so `host_mem_we` is high in the cycle after N+1. Minimum latency is 2 edges.
- Sustained rate is 1 word/cycle while `acc_idle=1` and `s_valid=1`.
- `host_mem_we` is high for exactly one cycle per word.
- `done` is high in the cycle immediately after the final `host_mem_we` cycle.
- `cmd_ready` returns high one cycle after `done`.
- For `cmd_len=0`: `done` is high in the cycle after command acceptance.

## Structure
- Shared package `loader_pkg` holds:
  - state encoding `LD_IDLE=2'd0`, `LD_LOAD=2'd1`, `LD_DONE=2'd2`;
  - default widths `LD_DATA_W=32`, `LD_ADDR_W=10`.
- Sub-module `sync_fifo` (parameters DATA_W, DEPTH) is a synchronous FIFO:
  - outputs `full`, `empty`, and a combinational head read;
  - same synchronous active-low reset;
  - pointer wrap-around is handled with an extra pointer bit.
- Top level contains the FSM, the address/length counters and the output registers.

## Test plan
- **Basic load:** reset, then cmd base=0x000, len=4 with data 0x02020202, 0x03030303, 0x04040404, 0x05050505 back-to-back, `acc_idle=1`.
  - Expect four consecutive `host_mem_we` pulses at addresses 0..3 with that data.
  - Expect `done` one cycle after the last pulse; SRAM[0]=0x02020202.
- **Idle gating:** same command with `acc_idle=0` for 10 cycles.
  - Expect `s_ready` to drop after 4 beats, `host_mem_we=0` throughout, then all 4 writes in order once `acc_idle=1`.
- **Address wrap:** base=0x3FE, len=3.
  - Expect writes at 0x3FE, 0x3FF, 0x000.
- **Zero length:** `cmd_len=0`.
  - Expect no write, `done` one cycle after acceptance, `s_ready` never high.
- **Reset mid-LOAD:** assert `rst_n=0` after 2 of 6 words are written.
  - Expect all outputs at reset values at the next edge, `cmd_ready=1`, and a fresh len=1 command writing correctly.
- **Backpressure and stray beats:** randomly toggle `s_valid`, and drive `s_valid` during IDLE.
  - Expect no beat accepted in IDLE, and the write sequence to equal the accepted-beat sequence exactly.
